char_ram_ctrl: RTL and testbench

CHAR_RAM_CTRL -- requirements
Module: char_ram_ctrl

---
 rtl/char_ram_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_char_ram_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_ram_ctrl.sv
// Character RAM write controller: two round-robin requesters, bulk clear, and a
// double-buffered bank swap on frame_start. Define CHAR_RAM_AUTOCLEAR_EN to clear the new back bank after every swap.
module char_ram_ctrl #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 8,
  parameter logic [7:0]  SPACE_CODE = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [6:0] col_a,
  input  logic [6:0] col_b,
  input  logic [2:0] row_a,
  input  logic [2:0] row_b,
  input  logic [7:0] char_a,
  input  logic [7:0] char_b,
  output logic       gnt_a,
  output logic       gnt_b,
  input  logic       clear_req,
  input  logic       swap_req,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       wren0,
  output logic       wren1,
  output logic       display_bank,
  output logic       busy,
  output logic       swap_pending,
  output logic       range_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [9:0] LAST_ADDR = 10'(COLS * ROWS - 1);

`ifdef CHAR_RAM_AUTOCLEAR_EN
  localparam logic AUTOCLEAR = 1'b1;
`else
  localparam logic AUTOCLEAR = 1'b0;
`endif

  state_t     r_state;
  logic       r_display_bank;
  logic       r_swap_pending;
  logic       r_clear_pending;
  logic       r_prio_b;
  logic [9:0] r_cnt;
  logic       r_gnt_a;
  logic       r_gnt_b;
  logic [9:0] r_ram_addr;
  logic [7:0] r_ram_data;
  logic       r_wren0;
  logic       r_wren1;
  logic       r_busy;
  logic       r_range_err;

  logic       w_swap_go;
  logic       w_bank_next;
  logic       w_start_clear;
  logic       w_pick_b;
  logic [6:0] w_col;
  logic [2:0] w_row;
  logic [7:0] w_char;
  logic       w_in_range;
  logic [9:0] w_addr;

  // Swap decision, arbitration and address generation for the current cycle.
  always_comb begin
    w_swap_go     = frame_start & (r_swap_pending | swap_req) & (r_state != CLEAR);
    w_bank_next   = r_display_bank ^ w_swap_go;
    w_start_clear = ((r_state == IDLE) & (clear_req | r_clear_pending)) | (AUTOCLEAR & w_swap_go);
    if (req_a && req_b) begin
      w_pick_b = r_prio_b;
    end else begin
      w_pick_b = req_b;
    end
    if (w_pick_b) begin
      w_col  = col_b;
      w_row  = row_b;
      w_char = char_b;
    end else begin
      w_col  = col_a;
      w_row  = row_a;
      w_char = char_a;
    end
    w_in_range = ({1'b0, w_col} < 8'(COLS)) && ({1'b0, w_row} < 4'(ROWS));
    w_addr     = 10'(w_row) * 10'(COLS) + 10'(w_col);
  end

  // Controller FSM with all outputs registered; the write lands during the WRITE/CLEAR cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_display_bank  <= 1'b0;
      r_swap_pending  <= 1'b0;
      r_clear_pending <= 1'b0;
      r_prio_b        <= 1'b0;
      r_cnt           <= 10'd0;
      r_gnt_a         <= 1'b0;
      r_gnt_b         <= 1'b0;
      r_ram_addr      <= 10'd0;
      r_ram_data      <= 8'd0;
      r_wren0         <= 1'b0;
      r_wren1         <= 1'b0;
      r_busy          <= 1'b0;
      r_range_err     <= 1'b0;
    end else begin
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_wren0 <= 1'b0;
      r_wren1 <= 1'b0;
      if (swap_req) begin
        r_swap_pending <= 1'b1;
      end
      if (w_swap_go) begin
        r_display_bank <= w_bank_next;
        r_swap_pending <= 1'b0;
      end
      if ((r_state == WRITE) && clear_req) begin
        r_clear_pending <= 1'b1;
      end
      // The back bank is taken from the post-swap display bank so a swap at this edge is honoured.
      if (w_start_clear) begin
        r_state         <= CLEAR;
        r_busy          <= 1'b1;
        r_clear_pending <= 1'b0;
        r_cnt           <= 10'd0;
        r_ram_addr      <= 10'd0;
        r_ram_data      <= SPACE_CODE;
        r_wren0         <= w_bank_next;
        r_wren1         <= ~w_bank_next;
      end else begin
        case (r_state)
          IDLE: begin
            if (req_a || req_b) begin
              r_state    <= WRITE;
              r_gnt_a    <= ~w_pick_b;
              r_gnt_b    <= w_pick_b;
              r_prio_b   <= ~w_pick_b;
              r_ram_addr <= w_addr;
              r_ram_data <= w_char;
              if (w_in_range) begin
                r_wren0 <= w_bank_next;
                r_wren1 <= ~w_bank_next;
              end else begin
                r_range_err <= 1'b1;
              end
            end else begin
              r_state <= IDLE;
            end
          end
          WRITE: begin
            r_state <= IDLE;
          end
          CLEAR: begin
            if (r_cnt == LAST_ADDR) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt      <= r_cnt + 10'd1;
              r_ram_addr <= r_cnt + 10'd1;
              r_wren0    <= w_bank_next;
              r_wren1    <= ~w_bank_next;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gnt_a        = r_gnt_a;
  assign gnt_b        = r_gnt_b;
  assign ram_addr     = r_ram_addr;
  assign ram_data     = r_ram_data;
  assign wren0        = r_wren0;
  assign wren1        = r_wren1;
  assign display_bank = r_display_bank;
  assign busy         = r_busy;
  assign swap_pending = r_swap_pending;
  assign range_err    = r_range_err;

endmodule

// File: tb/tb_char_ram_ctrl.sv
// Self-checking bench for char_ram_ctrl: reset, a vector table, directed clear/swap/reset
// sequences, and a randomized run against a transaction-level reference model.
module tb_char_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start, req_a, req_b, clear_req, swap_req;
  logic [6:0] col_a, col_b;
  logic [2:0] row_a, row_b;
  logic [7:0] char_a, char_b;
  logic       gnt_a, gnt_b, wren0, wren1, display_bank, busy, swap_pending, range_err;
  logic [9:0] ram_addr;
  logic [7:0] ram_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       b;
    logic [6:0] col;
    logic [2:0] row;
    logic [7:0] ch;
    logic [9:0] addr;
    logic       wr;
    logic       err;
  } vec_t;

  always #5 clk = ~clk;

  char_ram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .req_a(req_a), .req_b(req_b), .col_a(col_a), .col_b(col_b),
    .row_a(row_a), .row_b(row_b), .char_a(char_a), .char_b(char_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .clear_req(clear_req), .swap_req(swap_req),
    .ram_addr(ram_addr), .ram_data(ram_data), .wren0(wren0), .wren1(wren1),
    .display_bank(display_bank), .busy(busy), .swap_pending(swap_pending),
    .range_err(range_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    frame_start = 1'b0; req_a = 1'b0; req_b = 1'b0; clear_req = 1'b0; swap_req = 1'b0;
    col_a = 7'd0; col_b = 7'd0; row_a = 3'd0; row_b = 3'd0; char_a = 8'd0; char_b = 8'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic b, input logic [6:0] c, input logic [2:0] r,
                          input logic [7:0] ch, output logic got);
    got = 1'b0;
    if (b) begin
      req_b = 1'b1; col_b = c; row_b = r; char_b = ch;
    end else begin
      req_a = 1'b1; col_a = c; row_a = r; char_a = ch;
    end
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      got = b ? gnt_b : gnt_a;
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic wait_busy_low(input string nm);
    for (int k = 0; k < 2000 && busy; k++) tick();
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic got;
    int   bad;
    logic m_disp, m_pend, m_err, m_prio_b, prev_gnt;
    logic act_a, act_b, s_a, s_b, s_sw, s_fs, win_b, inr;
    logic [6:0] ta_c, tb_c, wc;
    logic [2:0] ta_r, tb_r, wr;
    logic [7:0] ta_ch, tb_ch, wch;
    int   wait_a, wait_b, max_wait;

    vecs[0] = '{1'b0, 7'd0,  3'd0, 8'h11, 10'd0,   1'b1, 1'b0};
    vecs[1] = '{1'b1, 7'd79, 3'd0, 8'h22, 10'd79,  1'b1, 1'b0};
    vecs[2] = '{1'b0, 7'd0,  3'd7, 8'h33, 10'd560, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 7'd79, 3'd7, 8'h44, 10'd639, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 7'd10, 3'd3, 8'h55, 10'd250, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 7'd85, 3'd0, 8'h66, 10'd0,   1'b0, 1'b1};
    vecs[6] = '{1'b0, 7'd127,3'd7, 8'h77, 10'd0,   1'b0, 1'b1};
    vecs[7] = '{1'b1, 7'd1,  3'd1, 8'h88, 10'd81,  1'b1, 1'b1};

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    tick();
    chk("rst_flags", 32'({gnt_a, gnt_b, wren0, wren1, display_bank, busy, swap_pending, range_err}), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_data", 32'(ram_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // First write: one cycle latency, back bank 1
    req_a = 1'b1; col_a = 7'd5; row_a = 3'd2; char_a = 8'h41;
    tick();
    chk("first_gnt", 32'({gnt_a, gnt_b}), 32'b10);
    chk("first_addr", 32'(ram_addr), 32'd165);
    chk("first_data", 32'(ram_data), 32'h41);
    chk("first_wren", 32'({wren0, wren1}), 32'b01);
    req_a = 1'b0;
    tick();
    chk("first_gnt_one_cycle", 32'({gnt_a, wren1}), 32'd0);

    // Vector table
    foreach (vecs[i]) begin
      do_write(vecs[i].b, vecs[i].col, vecs[i].row, vecs[i].ch, got);
      chk($sformatf("vec%0d_gnt", i), 32'(got), 32'd1);
      chk($sformatf("vec%0d_other_gnt", i), 32'(vecs[i].b ? gnt_a : gnt_b), 32'd0);
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
        chk($sformatf("vec%0d_data", i), 32'(ram_data), 32'(vecs[i].ch));
      end
      chk($sformatf("vec%0d_wren", i), 32'({wren0, wren1}), 32'({1'b0, vecs[i].wr}));
      chk($sformatf("vec%0d_range_err", i), 32'(range_err), 32'(vecs[i].err));
      tick();
    end

    // Round robin with both requesters held
    do_reset();
    req_a = 1'b1; col_a = 7'd1; row_a = 3'd0; char_a = 8'hA1;
    req_b = 1'b1; col_b = 7'd2; row_b = 3'd0; char_b = 8'hB2;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] e;
      tick();
      e = (k % 2 == 1) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("rr_cycle%0d", k), 32'({gnt_a, gnt_b}), 32'(e));
      if (k == 2) chk("rr_b_addr", 32'(ram_addr), 32'd2);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();

    // Clear with a competing req_b and a clear_req ignored mid-clear
    clear_req = 1'b1;
    req_b = 1'b1; col_b = 7'd4; row_b = 3'd0; char_b = 8'hAB;
    tick();
    clear_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 640; i++) begin
      if ({busy, wren0, wren1, gnt_a, gnt_b} !== 5'b10100 || ram_addr !== 10'(i) || ram_data !== 8'h00)
        bad++;
      clear_req = (i == 100);
      tick();
    end
    clear_req = 1'b0;
    chk("clear_cycles_bad", 32'(bad), 32'd0);
    chk("clear_exit_busy", 32'(busy), 32'd0);
    chk("clear_exit_no_gnt", 32'(gnt_b), 32'd0);
    tick();
    chk("clear_then_gnt_b", 32'(gnt_b), 32'd1);
    chk("clear_then_addr", 32'(ram_addr), 32'd4);
    chk("clear_then_wren", 32'({wren0, wren1}), 32'b01);
    req_b = 1'b0;
    tick();
    chk("clear_req_ignored", 32'(busy), 32'd0);

    // Swap at frame_start ten cycles after swap_req
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_pending_set", 32'({swap_pending, display_bank}), 32'b10);
    for (int k = 0; k < 9; k++) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("swap_applied", 32'({swap_pending, display_bank}), 32'b01);
    do_write(1'b0, 7'd0, 3'd1, 8'h5A, got);
    chk("swap_write_gnt", 32'(got), 32'd1);
    chk("swap_write_wren0", 32'({wren0, wren1}), 32'b10);
    chk("swap_write_addr", 32'(ram_addr), 32'd80);
    tick();

    // Swap deferred while busy
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("defer_clear_bank0", 32'({busy, wren0, wren1}), 32'b110);
    for (int k = 0; k < 5; k++) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("defer_held", 32'({swap_pending, display_bank}), 32'b11);
    wait_busy_low("defer_busy_fall");
    tick();
    tick();
    chk("defer_still_held", 32'({swap_pending, display_bank}), 32'b11);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("defer_applied", 32'({swap_pending, display_bank}), 32'b00);

    // clear_req during WRITE is latched and served on next IDLE
    do_write(1'b0, 7'd3, 3'd3, 8'h12, got);
    chk("latch_gnt", 32'(got), 32'd1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("latch_not_yet", 32'(busy), 32'd0);
    tick();
    chk("latch_started", 32'(busy), 32'd1);
    wait_busy_low("latch_busy_fall");

    // Reset in the middle of a clear
    do_reset();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 300; k++) tick();
    chk("midclr_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midclr_async", 32'({busy, wren0, wren1, display_bank}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (wren0 || wren1 || busy) bad++;
    end
    chk("midclr_no_writes", 32'(bad), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    m_disp = 1'b0; m_pend = 1'b0; m_err = 1'b0; m_prio_b = 1'b0; prev_gnt = 1'b0;
    act_a = 1'b0; act_b = 1'b0; wait_a = 0; wait_b = 0; max_wait = 0;
    ta_c = 7'd0; ta_r = 3'd0; ta_ch = 8'd0; tb_c = 7'd0; tb_r = 3'd0; tb_ch = 8'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!act_a && $urandom_range(0, 99) < 40) begin
        act_a = 1'b1; wait_a = 0;
        ta_c = 7'($urandom_range(0, 90)); ta_r = 3'($urandom_range(0, 7)); ta_ch = 8'($urandom);
      end
      if (!act_b && $urandom_range(0, 99) < 40) begin
        act_b = 1'b1; wait_b = 0;
        tb_c = 7'($urandom_range(0, 90)); tb_r = 3'($urandom_range(0, 7)); tb_ch = 8'($urandom);
      end
      req_a = act_a; col_a = ta_c; row_a = ta_r; char_a = ta_ch;
      req_b = act_b; col_b = tb_c; row_b = tb_r; char_b = tb_ch;
      swap_req = ($urandom_range(0, 99) < 6);
      frame_start = ($urandom_range(0, 99) < 8);
      s_a = req_a; s_b = req_b; s_sw = swap_req; s_fs = frame_start;
      tick();
      if (s_fs && (m_pend || s_sw)) begin
        m_disp = ~m_disp;
        m_pend = 1'b0;
      end else if (s_sw) begin
        m_pend = 1'b1;
      end
      chk("rnd_display_bank", 32'(display_bank), 32'(m_disp));
      chk("rnd_swap_pending", 32'(swap_pending), 32'(m_pend));
      chk("rnd_single_gnt", 32'(gnt_a & gnt_b), 32'd0);
      if (gnt_a || gnt_b) begin
        win_b = gnt_b;
        if (s_a && s_b) chk("rnd_round_robin", 32'(win_b), 32'(m_prio_b));
        else chk("rnd_gnt_source", 32'(win_b ? s_b : s_a), 32'd1);
        chk("rnd_gnt_spacing", 32'(prev_gnt), 32'd0);
        m_prio_b = ~win_b;
        wc  = win_b ? tb_c : ta_c;
        wr  = win_b ? tb_r : ta_r;
        wch = win_b ? tb_ch : ta_ch;
        inr = (wc < 7'd80);
        if (inr) begin
          chk("rnd_addr", 32'(ram_addr), 32'(int'(wr) * 80 + int'(wc)));
          chk("rnd_data", 32'(ram_data), 32'(wch));
        end
        chk("rnd_wren", 32'({wren0, wren1}), inr ? (m_disp ? 32'b10 : 32'b01) : 32'b00);
        if (!inr) m_err = 1'b1;
        if (win_b) act_b = 1'b0;
        else act_a = 1'b0;
        prev_gnt = 1'b1;
      end else begin
        chk("rnd_no_write", 32'({wren0, wren1}), 32'd0);
        prev_gnt = 1'b0;
      end
      chk("rnd_range_err", 32'(range_err), 32'(m_err));
      if (act_a && s_a) wait_a++;
      if (act_b && s_b) wait_b++;
      if (wait_a > max_wait) max_wait = wait_a;
      if (wait_b > max_wait) max_wait = wait_b;
    end
    chk("rnd_max_wait_ok", 32'(max_wait <= 6), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
